// File: rtl/axi4_slave_pkg.sv
// Shared constants, state enums and command payload for the AXI4 slave RAM.
// Holds the AXI response and burst codes, the write/read FSM state types,
// the latched burst command struct, and a helper that maps burst type and
// protocol error onto a response code.
package axi4_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Command fields latched at an address handshake
    typedef struct packed {
        logic [3:0] id;
        logic [7:0] len;
        logic [1:0] burst;
    } burst_cmd_t;

    // Only INCR bursts are served cleanly; any protocol error also yields SLVERR
    function automatic logic [1:0] burst_resp(input logic [1:0] burst, input logic err);
        logic [1:0] resp;
        case (burst)
            BURST_INCR:              resp = err ? RESP_SLVERR : RESP_OKAY;
            BURST_FIXED, BURST_WRAP: resp = RESP_SLVERR;
            default:                 resp = RESP_SLVERR;
        endcase
        return resp;
    endfunction

endpackage

// File: rtl/axi4_slave_mem.sv
// Word-organised storage for the AXI4 slave RAM.
// Ports:
//   clk        rising-edge clock for the write port
//   wr_en      write enable for the addressed word
//   wr_idx     word index written
//   wr_data    write data
//   wr_strb    per-byte write enables
//   rd_idx     word index read
//   rd_data_c  combinational read data (returns pre-write contents on a same-cycle collision)
// Contents are never reset.
module axi4_slave_mem #(
    parameter int unsigned  DATA_W = 64,
    parameter int unsigned  DEPTH  = 1024,
    localparam int unsigned STRB_W = DATA_W / 8,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-enabled write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by a single-ported-write / single-ported-read RAM.
// Independent write (AW/W/B) and read (AR/R) engines, one burst outstanding
// each. Addresses advance one word per beat and wrap modulo MEM_DEPTH for
// every burst type; non-INCR bursts and misplaced WLAST are answered SLVERR.
// Ports:
//   aclk, resetn          clock, synchronous active-low reset
//   s_axi_aw*             write address channel (size/prot/qos/lock/cache ignored)
//   s_axi_w*              write data channel
//   s_axi_b*              write response channel
//   s_axi_ar*             read address channel (size/prot/qos/lock/cache ignored)
//   s_axi_r*              read data channel
module axi4_slave_ram
    import axi4_slave_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH      = 1024
) (
    input  logic                        aclk,
    input  logic                        resetn,

    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [3:0]                  s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [1:0]                  s_axi_awburst,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [2:0]                  s_axi_awport,
    input  logic [3:0]                  s_axi_awqos,
    input  logic                        s_axi_awlock,
    input  logic [3:0]                  s_axi_awcache,

    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,

    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [3:0]                  s_axi_bid,
    output logic [1:0]                  s_axi_bresp,

    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [3:0]                  s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [1:0]                  s_axi_arburst,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [2:0]                  s_axi_arport,
    input  logic [3:0]                  s_axi_arqos,
    input  logic                        s_axi_arlock,
    input  logic [3:0]                  s_axi_arcache,

    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [3:0]                  s_axi_rid,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

    // Sideband fields carry no meaning for a flat RAM
    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awsize, s_axi_awport, s_axi_awqos, s_axi_awlock, s_axi_awcache,
                               s_axi_arsize, s_axi_arport, s_axi_arqos, s_axi_arlock, s_axi_arcache};

    // ---------------- write engine state ----------------
    w_state_t          w_state_q, w_state_d;
    burst_cmd_t        aw_cmd_q, aw_cmd_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic [7:0]        w_beat_q, w_beat_d;
    logic              w_err_q, w_err_d;
    logic              awready_d, wready_d, bvalid_d;
    logic [3:0]        bid_d;
    logic [1:0]        bresp_d;
    logic              mem_we_c;

    // ---------------- read engine state ----------------
    r_state_t          r_state_q, r_state_d;
    burst_cmd_t        ar_cmd_q, ar_cmd_d;
    logic [IDX_W-1:0]  ar_idx_q, ar_idx_d;
    logic [7:0]        r_beat_q, r_beat_d;
    logic [7:0]        r_next_beat_c;
    logic              arready_d, rvalid_d, rlast_d;
    logic [3:0]        rid_d;
    logic [1:0]        rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_d;

    logic [IDX_W-1:0]          wr_idx_c, rd_idx_c, ar_start_idx_c;
    logic [AXI_DATA_WIDTH-1:0] mem_rd_c;

    assign wr_idx_c       = aw_idx_q + IDX_W'(w_beat_q);
    assign ar_start_idx_c = IDX_W'(s_axi_araddr >> OFF_W);
    assign r_next_beat_c  = 8'(r_beat_q + 8'd1);
    // Idle: look up the first beat so it can load on the AR handshake; busy: prefetch the next beat
    assign rd_idx_c       = (r_state_q == R_IDLE) ? ar_start_idx_c
                                                  : ar_idx_q + IDX_W'(r_next_beat_c);

    axi4_slave_mem #(
        .DATA_W (AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk       (aclk),
        .wr_en     (mem_we_c && resetn),
        .wr_idx    (wr_idx_c),
        .wr_data   (s_axi_wdata),
        .wr_strb   (s_axi_wstrb),
        .rd_idx    (rd_idx_c),
        .rd_data_c (mem_rd_c)
    );

    // Write engine next state
    always_comb begin
        w_state_d = w_state_q;
        aw_cmd_d  = aw_cmd_q;
        aw_idx_d  = aw_idx_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        bid_d     = s_axi_bid;
        bresp_d   = s_axi_bresp;
        mem_we_c  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_cmd_d.id    = s_axi_awid;
                    aw_cmd_d.len   = s_axi_awlen;
                    aw_cmd_d.burst = s_axi_awburst;
                    aw_idx_d       = IDX_W'(s_axi_awaddr >> OFF_W);
                    w_beat_d       = 8'd0;
                    w_err_d        = 1'b0;
                    w_state_d      = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && s_axi_wready) begin
                    mem_we_c = 1'b1;
                    w_beat_d = 8'(w_beat_q + 8'd1);
                    if (w_beat_q == aw_cmd_q.len) begin
                        bresp_d   = burst_resp(aw_cmd_q.burst, w_err_q || !s_axi_wlast);
                        bid_d     = aw_cmd_q.id;
                        w_state_d = W_RESP;
                    end else if (s_axi_wlast) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read engine next state; R outputs only change on a handshake so they hold while stalled
    always_comb begin
        r_state_d = r_state_q;
        ar_cmd_d  = ar_cmd_q;
        ar_idx_d  = ar_idx_q;
        r_beat_d  = r_beat_q;
        rdata_d   = s_axi_rdata;
        rid_d     = s_axi_rid;
        rresp_d   = s_axi_rresp;
        rlast_d   = s_axi_rlast;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    ar_cmd_d.id    = s_axi_arid;
                    ar_cmd_d.len   = s_axi_arlen;
                    ar_cmd_d.burst = s_axi_arburst;
                    ar_idx_d       = ar_start_idx_c;
                    r_beat_d       = 8'd0;
                    rdata_d        = mem_rd_c;
                    rid_d          = s_axi_arid;
                    rresp_d        = burst_resp(s_axi_arburst, 1'b0);
                    rlast_d        = (s_axi_arlen == 8'd0);
                    r_state_d      = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (s_axi_rlast) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_next_beat_c;
                        rdata_d  = mem_rd_c;
                        rid_d    = ar_cmd_q.id;
                        rresp_d  = burst_resp(ar_cmd_q.burst, 1'b0);
                        rlast_d  = (r_next_beat_c == ar_cmd_q.len);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // State and output registers
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            w_state_q     <= W_IDLE;
            aw_cmd_q      <= '0;
            aw_idx_q      <= '0;
            w_beat_q      <= '0;
            w_err_q       <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= '0;
            r_state_q     <= R_IDLE;
            ar_cmd_q      <= '0;
            ar_idx_q      <= '0;
            r_beat_q      <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= '0;
            s_axi_rdata   <= '0;
        end else begin
            w_state_q     <= w_state_d;
            aw_cmd_q      <= aw_cmd_d;
            aw_idx_q      <= aw_idx_d;
            w_beat_q      <= w_beat_d;
            w_err_q       <= w_err_d;
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bid     <= bid_d;
            s_axi_bresp   <= bresp_d;
            r_state_q     <= r_state_d;
            ar_cmd_q      <= ar_cmd_d;
            ar_idx_q      <= ar_idx_d;
            r_beat_q      <= r_beat_d;
            s_axi_arready <= arready_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rlast   <= rlast_d;
            s_axi_rid     <= rid_d;
            s_axi_rresp   <= rresp_d;
            s_axi_rdata   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Self-checking bench for axi4_slave_ram: a table of directed bursts, hand-written
// corner sequences, and randomized bursts checked against a byte-level memory model.
module tb_axi4_slave_ram;
    import axi4_slave_pkg::*;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          s_axi_awvalid, s_axi_awready;
    logic [AW-1:0] s_axi_awaddr;
    logic [3:0]    s_axi_awid;
    logic [7:0]    s_axi_awlen;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_wvalid, s_axi_wready;
    logic [DW-1:0] s_axi_wdata;
    logic [7:0]    s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_bvalid, s_axi_bready;
    logic [3:0]    s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic [3:0]    s_axi_arid;
    logic [7:0]    s_axi_arlen;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_rvalid, s_axi_rready;
    logic [DW-1:0] s_axi_rdata;
    logic [3:0]    s_axi_rid;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;

    axi4_slave_ram #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awsize  (3'd3),
        .s_axi_awport  (3'd0),
        .s_axi_awqos   (4'd0),
        .s_axi_awlock  (1'b0),
        .s_axi_awcache (4'd0),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arid    (s_axi_arid),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arsize  (3'd3),
        .s_axi_arport  (3'd0),
        .s_axi_arqos   (4'd0),
        .s_axi_arlock  (1'b0),
        .s_axi_arcache (4'd0),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast)
    );

    always #5 aclk = ~aclk;

    // Reference memory: word contents plus a per-byte "known" mask
    logic [63:0] mdl [DEPTH];
    logic [7:0]  kn  [DEPTH];
    logic [63:0] wbuf [256];
    logic [7:0]  sbuf [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rd_addr;
        logic [3:0]  id;
        int          len;
        logic [1:0]  burst;
        logic [7:0]  strb;
        logic [63:0] d0;
        logic [63:0] step;
        int          wlast_mode;   // 0 correct, 1 wlast on beat 0 only, 2 never
        logic [1:0]  exp_bresp;
        logic [63:0] exp_rd0;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return s_axi_awready;
            1:       return s_axi_wready;
            2:       return s_axi_arready;
            3:       return s_axi_bvalid;
            default: return s_axi_rvalid;
        endcase
    endfunction

    // Bounded wait, sampled on the falling edge
    task automatic wait_hi(input int sel, input string name);
        int n = 0;
        while (sel_val(sel) !== 1'b1 && n < 64) begin
            @(negedge aclk);
            n++;
        end
        if (sel_val(sel) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: got 0 after %0d cycles, want 1", name, n);
        end
    endtask

    function automatic int widx(input logic [31:0] addr, input int beat);
        return int'(((addr >> 3) + 32'(beat)) % 32'(DEPTH));
    endfunction

    function automatic logic [63:0] kmask(input int idx);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = kn[idx][k] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int beat);
        int idx = widx(addr, beat);
        for (int k = 0; k < 8; k++) begin
            if (sbuf[beat][k]) begin
                mdl[idx][8*k +: 8] = wbuf[beat][8*k +: 8];
                kn[idx][k] = 1'b1;
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [1:0] burst, input int wlast_mode, input int bdelay,
                            input logic [1:0] exp_bresp, input string tag);
        s_axi_awaddr  = addr;
        s_axi_awid    = id;
        s_axi_awlen   = 8'(len);
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        wait_hi(0, {tag, " awready"});
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s_axi_wdata  = wbuf[b];
            s_axi_wstrb  = sbuf[b];
            s_axi_wlast  = (wlast_mode == 0) ? (b == len) : (wlast_mode == 1) ? (b == 0) : 1'b0;
            s_axi_wvalid = 1'b1;
            wait_hi(1, {tag, " wready"});
            @(negedge aclk);
            model_write(addr, b);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        chk({tag, " bvalid latency"}, 64'(s_axi_bvalid), 64'(1));
        for (int d = 0; d < bdelay; d++) begin
            @(negedge aclk);
            chk({tag, " bvalid held"}, 64'(s_axi_bvalid), 64'(1));
        end
        chk({tag, " bresp"}, 64'(s_axi_bresp), 64'(exp_bresp));
        chk({tag, " bid"}, 64'(s_axi_bid), 64'(id));
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        chk({tag, " bvalid drop"}, 64'(s_axi_bvalid), 64'(0));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [1:0] burst, input logic [1:0] exp_rresp, input bit stall,
                           input string tag, output logic [63:0] first);
        int          idx;
        logic [63:0] m;
        first = '0;
        s_axi_araddr  = addr;
        s_axi_arid    = id;
        s_axi_arlen   = 8'(len);
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        wait_hi(2, {tag, " arready"});
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            idx = widx(addr, i);
            m   = kmask(idx);
            if (i == 0) first = s_axi_rdata;
            chk({tag, " rvalid"}, 64'(s_axi_rvalid), 64'(1));
            if (m != 64'd0) chk({tag, " rdata"}, s_axi_rdata & m, mdl[idx] & m);
            chk({tag, " rid"}, 64'(s_axi_rid), 64'(id));
            chk({tag, " rresp"}, 64'(s_axi_rresp), 64'(exp_rresp));
            chk({tag, " rlast"}, 64'(s_axi_rlast), 64'(i == len));
            if (stall && $urandom_range(0, 1) == 0) begin
                s_axi_rready = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge aclk);
                    chk({tag, " stall rvalid"}, 64'(s_axi_rvalid), 64'(1));
                    if (m != 64'd0) chk({tag, " stall rdata"}, s_axi_rdata & m, mdl[idx] & m);
                    chk({tag, " stall rlast"}, 64'(s_axi_rlast), 64'(i == len));
                end
            end
            s_axi_rready = 1'b1;
            @(negedge aclk);
        end
        s_axi_rready = 1'b0;
        chk({tag, " rvalid end"}, 64'(s_axi_rvalid), 64'(0));
        chk({tag, " arready end"}, 64'(s_axi_arready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] first;
        logic [31:0] addr;
        logic [1:0]  burst, rburst, eb;
        int          len, mode;

        for (int i = 0; i < int'(DEPTH); i++) begin
            kn[i]  = 8'h00;
            mdl[i] = 64'd0;
        end
        resetn = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awburst = '0;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arburst = '0;
        s_axi_rready = 1'b0;

        vt[0] = '{32'h100,  32'h100,  4'd5, 3, BURST_INCR,  8'hFF, 64'h11, 64'h11, 0, RESP_OKAY,   64'h11};
        vt[1] = '{32'h200,  32'h200,  4'd1, 0, BURST_INCR,  8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 0, RESP_OKAY, 64'hAAAA_AAAA_AAAA_AAAA};
        vt[2] = '{32'h200,  32'h200,  4'd2, 0, BURST_INCR,  8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, RESP_OKAY, 64'hAAAA_AAAA_FFFF_FFFF};
        vt[3] = '{32'h300,  32'h300,  4'd3, 1, BURST_INCR,  8'hFF, 64'h3000, 64'd1, 1, RESP_SLVERR, 64'h3000};
        vt[4] = '{32'h400,  32'h400,  4'd4, 2, BURST_FIXED, 8'hFF, 64'h4000, 64'd1, 0, RESP_SLVERR, 64'h4000};
        vt[5] = '{32'h1FF8, 32'h1FF8, 4'd6, 1, BURST_INCR,  8'hFF, 64'h5000, 64'd1, 0, RESP_OKAY,   64'h5000};
        vt[6] = '{32'h503,  32'h500,  4'd7, 0, BURST_INCR,  8'hFF, 64'h6000_0000_0000_0001, 64'd0, 0, RESP_OKAY, 64'h6000_0000_0000_0001};
        vt[7] = '{32'h600,  32'h600,  4'd8, 2, BURST_INCR,  8'hFF, 64'h7000, 64'd1, 2, RESP_SLVERR, 64'h7000};

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst awready", 64'(s_axi_awready), 64'(0));
        chk("rst wready",  64'(s_axi_wready),  64'(0));
        chk("rst arready", 64'(s_axi_arready), 64'(0));
        chk("rst bvalid",  64'(s_axi_bvalid),  64'(0));
        chk("rst rvalid",  64'(s_axi_rvalid),  64'(0));
        chk("rst rlast",   64'(s_axi_rlast),   64'(0));
        chk("rst bresp",   64'(s_axi_bresp),   64'(0));
        chk("rst rresp",   64'(s_axi_rresp),   64'(0));
        chk("rst bid",     64'(s_axi_bid),     64'(0));
        chk("rst rid",     64'(s_axi_rid),     64'(0));
        chk("rst rdata",   s_axi_rdata,        64'(0));
        resetn = 1'b1;
        @(negedge aclk);
        chk("post-rst awready", 64'(s_axi_awready), 64'(1));
        chk("post-rst arready", 64'(s_axi_arready), 64'(1));

        // Directed table: write then read back each burst
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b <= vt[r].len; b++) begin
                wbuf[b] = vt[r].d0 + 64'(b) * vt[r].step;
                sbuf[b] = vt[r].strb;
            end
            do_write(vt[r].addr, vt[r].id, vt[r].len, vt[r].burst, vt[r].wlast_mode, 0,
                     vt[r].exp_bresp, $sformatf("vec%0d wr", r));
            do_read(vt[r].rd_addr, vt[r].id, vt[r].len, BURST_INCR, RESP_OKAY, 1'b0,
                    $sformatf("vec%0d rd", r), first);
            chk($sformatf("vec%0d first word", r), first, vt[r].exp_rd0);
        end

        // Non-INCR read returns SLVERR on every beat
        do_read(32'h100, 4'd9, 3, BURST_FIXED, RESP_SLVERR, 1'b0, "fixed rd", first);
        chk("fixed rd first", first, 64'h11);

        // Second beat of the burst at the top word wrapped to word 0
        do_read(32'h0, 4'd10, 0, BURST_INCR, RESP_OKAY, 1'b0, "wrap rd", first);
        chk("wrap word0", first, 64'h5001);

        // Stalled bresp and stalled long read
        for (int b = 0; b < 8; b++) begin
            wbuf[b] = {$urandom(), $urandom()};
            sbuf[b] = 8'hFF;
        end
        do_write(32'hA00, 4'd11, 7, BURST_INCR, 0, 5, RESP_OKAY, "bstall wr");
        do_read(32'hA00, 4'd12, 7, BURST_INCR, RESP_OKAY, 1'b1, "rstall rd", first);

        // Same-cycle write and read of word 0x100 returns the old value
        s_axi_awaddr = 32'h100; s_axi_awid = 4'd3; s_axi_awlen = 8'd0; s_axi_awburst = BURST_INCR;
        s_axi_awvalid = 1'b1;
        wait_hi(0, "rbw awready");
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 64'hDEAD_BEEF; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h100; s_axi_arid = 4'd2; s_axi_arlen = 8'd0; s_axi_arburst = BURST_INCR;
        s_axi_arvalid = 1'b1;
        chk("rbw wready", 64'(s_axi_wready), 64'(1));
        chk("rbw arready", 64'(s_axi_arready), 64'(1));
        @(negedge aclk);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        chk("rbw rvalid", 64'(s_axi_rvalid), 64'(1));
        chk("rbw old data", s_axi_rdata, 64'h11);
        chk("rbw bvalid", 64'(s_axi_bvalid), 64'(1));
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        mdl[32] = 64'hDEAD_BEEF;
        kn[32]  = 8'hFF;
        do_read(32'h100, 4'd2, 0, BURST_INCR, RESP_OKAY, 1'b0, "rbw reread", first);
        chk("rbw new data", first, 64'hDEAD_BEEF);

        // Reset in the middle of a write burst
        s_axi_awaddr = 32'h800; s_axi_awid = 4'd9; s_axi_awlen = 8'd7; s_axi_awburst = BURST_INCR;
        s_axi_awvalid = 1'b1;
        wait_hi(0, "abort awready");
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wbuf[b] = 64'hB0 + 64'(b);
            sbuf[b] = 8'hFF;
            s_axi_wdata = wbuf[b]; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
            wait_hi(1, "abort wready");
            @(negedge aclk);
            model_write(32'h800, b);
        end
        s_axi_wdata = 64'hB2;
        resetn = 1'b0;
        @(negedge aclk);
        s_axi_wvalid = 1'b0;
        kn[widx(32'h800, 2)] = 8'h00;
        chk("abort rst awready", 64'(s_axi_awready), 64'(0));
        chk("abort rst wready",  64'(s_axi_wready),  64'(0));
        chk("abort rst bvalid",  64'(s_axi_bvalid),  64'(0));
        resetn = 1'b1;
        @(negedge aclk);
        chk("abort awready", 64'(s_axi_awready), 64'(1));
        chk("abort arready", 64'(s_axi_arready), 64'(1));
        repeat (3) @(negedge aclk);
        chk("abort no bvalid", 64'(s_axi_bvalid), 64'(0));
        do_read(32'h800, 4'd1, 2, BURST_INCR, RESP_OKAY, 1'b0, "abort partial", first);
        chk("abort beat0 kept", first, 64'hB0);
        do_read(32'h100, 4'd1, 3, BURST_INCR, RESP_OKAY, 1'b0, "abort retained", first);

        // Randomized bursts against the model
        for (int t = 0; t < 25; t++) begin
            addr  = (32'($urandom_range(0, DEPTH - 1)) << 3) | 32'($urandom_range(0, 7));
            len   = $urandom_range(0, 7);
            burst = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : BURST_INCR;
            mode  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            for (int b = 0; b <= len; b++) begin
                wbuf[b] = {$urandom(), $urandom()};
                sbuf[b] = 8'($urandom_range(0, 255));
            end
            eb = (burst != BURST_INCR || mode == 2 || (mode == 1 && len > 0)) ? RESP_SLVERR : RESP_OKAY;
            do_write(addr, 4'($urandom_range(0, 15)), len, burst, mode, $urandom_range(0, 3), eb,
                     $sformatf("rnd%0d wr", t));
            rburst = ($urandom_range(0, 3) == 0) ? BURST_WRAP : BURST_INCR;
            do_read(addr, 4'($urandom_range(0, 15)), len, rburst,
                    (rburst == BURST_INCR) ? RESP_OKAY : RESP_SLVERR, 1'b1,
                    $sformatf("rnd%0d rd", t), first);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
